gcm_seq_ctrl: RTL

Job sequencer in front of the gcm_aes core. It accepts one GCM job (key, IV, AAD and plaintext lengths) and then a gap-free stream of 128-bit blocks. It drives the core's instance strobes, block inputs and size fields, realigns ciphertext to the core's fixed latency, and captures the tag with a watchdog. Sits between the host/DMA block stream and gcm_aes.

---
 rtl/gcm_seq_ctrl.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/gcm_seq_ctrl.sv
// gcm_seq_ctrl: job sequencer in front of the gcm_aes core.
//
// Accepts one GCM job (key, IV, AAD/PT block counts), then a gap-free stream of
// 128-bit blocks. Drives the core's instance strobes, registered block inputs and
// bit-length fields, realigns ciphertext to the core's fixed latency and captures
// the tag under a watchdog.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_start, i_key, i_iv       job start (IDLE only) and latched job parameters
//   i_aad_blks, i_pt_blks      per-phase block counts (0 allowed)
//   i_blk, i_blk_valid         block stream; o_blk_ready high in AAD/PT
//   o_busy                     state != IDLE
//   o_ct, o_ct_valid           realigned ciphertext, one pulse per PT block
//   o_tag, o_tag_valid         captured tag, one-cycle completion pulse
//   o_err                      sticky underrun/timeout flag, cleared on start
//   o_core_*                   drive gcm_aes inputs
//   i_core_ct/tag/tag_ready    gcm_aes outputs
//
// Optional: define GCM_SEQ_PERF_EN to add o_perf_cycles, a saturating 32-bit count
// of cycles from accepted start to tag or error.

module gcm_seq_ctrl #(
   parameter int unsigned LEN_W       = 16,
   parameter int unsigned CT_LATENCY  = 1,
   parameter int unsigned TAG_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [127:0]     i_key,
   input  logic [95:0]      i_iv,
   input  logic [LEN_W-1:0] i_aad_blks,
   input  logic [LEN_W-1:0] i_pt_blks,
   input  logic [127:0]     i_blk,
   input  logic             i_blk_valid,
   output logic             o_blk_ready,
   output logic             o_busy,
   output logic [127:0]     o_ct,
   output logic             o_ct_valid,
   output logic [127:0]     o_tag,
   output logic             o_tag_valid,
   output logic             o_err,
   output logic             o_core_new_instance,
   output logic             o_core_pt_instance,
   output logic [127:0]     o_core_key,
   output logic [95:0]      o_core_iv,
   output logic [127:0]     o_core_aad,
   output logic [127:0]     o_core_pt,
   output logic [63:0]      o_core_aad_size,
   output logic [63:0]      o_core_pt_size,
   input  logic [127:0]     i_core_ct,
   input  logic [127:0]     i_core_tag,
   input  logic             i_core_tag_ready
`ifdef GCM_SEQ_PERF_EN
   ,
   output logic [31:0]      o_perf_cycles
`endif
);

   localparam int unsigned TO_W = $clog2(TAG_TIMEOUT + 1);

   typedef enum logic [2:0] {StIdle, StAad, StPt, StWaitTag, StErr} state_e;

   state_e                state_q, state_d;
   logic [LEN_W-1:0]      cnt_q, cnt_d;
   logic [LEN_W-1:0]      pt_blks_q, pt_blks_d;
   logic                  first_q, first_d;
   logic [TO_W-1:0]       to_q, to_d;
   logic [CT_LATENCY-1:0] ct_sr_q, ct_sr_d;
   logic [127:0]          key_q, key_d, aad_q, aad_d, pt_q, pt_d;
   logic [95:0]           iv_q, iv_d;
   logic [63:0]           aad_size_q, aad_size_d, pt_size_q, pt_size_d;
   logic                  new_inst_q, new_inst_d, pt_inst_q, pt_inst_d;
   logic [127:0]          ct_q, ct_d, tag_q, tag_d;
   logic                  ct_valid_q, ct_valid_d, tag_valid_q, tag_valid_d;
   logic                  err_q, err_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pt_blks_d   = pt_blks_q;
      first_d     = first_q;
      to_d        = to_q;
      key_d       = key_q;
      iv_d        = iv_q;
      aad_d       = aad_q;
      pt_d        = pt_q;
      aad_size_d  = aad_size_q;
      pt_size_d   = pt_size_q;
      new_inst_d  = 1'b0;
      pt_inst_d   = 1'b0;
      tag_d       = tag_q;
      tag_valid_d = 1'b0;
      err_d       = err_q;

      unique case (state_q)
         StIdle: begin
            if (i_start) begin
               key_d      = i_key;
               iv_d       = i_iv;
               aad_size_d = 64'(i_aad_blks) << 7;
               pt_size_d  = 64'(i_pt_blks) << 7;
               pt_blks_d  = i_pt_blks;
               err_d      = 1'b0;
               first_d    = 1'b1;
               to_d       = '0;
               if (i_aad_blks != '0) begin
                  state_d = StAad;
                  cnt_d   = i_aad_blks;
               end else if (i_pt_blks != '0) begin
                  state_d = StPt;
                  cnt_d   = i_pt_blks;
               end else begin
                  // Empty job: the core still needs one instance pulse.
                  state_d    = StWaitTag;
                  new_inst_d = 1'b1;
               end
            end
         end
         StAad: begin
            if (!i_blk_valid) begin
               state_d = StErr;
               err_d   = 1'b1;
            end else begin
               aad_d      = i_blk;
               new_inst_d = first_q;
               first_d    = 1'b0;
               cnt_d      = cnt_q - 1'b1;
               if (cnt_q == LEN_W'(1)) begin
                  if (pt_blks_q != '0) begin
                     state_d = StPt;
                     cnt_d   = pt_blks_q;
                  end else begin
                     state_d = StWaitTag;
                  end
               end
            end
         end
         StPt: begin
            if (!i_blk_valid) begin
               state_d = StErr;
               err_d   = 1'b1;
            end else begin
               pt_d       = i_blk;
               new_inst_d = first_q;
               pt_inst_d  = 1'b1;
               first_d    = 1'b0;
               cnt_d      = cnt_q - 1'b1;
               if (cnt_q == LEN_W'(1)) state_d = StWaitTag;
            end
         end
         StWaitTag: begin
            // Tag takes priority over a timeout expiring in the same cycle.
            if (i_core_tag_ready) begin
               tag_d       = i_core_tag;
               tag_valid_d = 1'b1;
               state_d     = StIdle;
            end else if (to_q == TO_W'(TAG_TIMEOUT - 1)) begin
               state_d = StErr;
               err_d   = 1'b1;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Ciphertext realignment: the valid tap follows each PT presentation by CT_LATENCY
   // cycles, at which point i_core_ct holds the matching result.
   always_comb begin
      ct_sr_d    = CT_LATENCY'({ct_sr_q, pt_inst_q});
      ct_valid_d = ct_sr_q[CT_LATENCY-1];
      if (state_q == StErr) begin
         ct_sr_d    = '0;
         ct_valid_d = 1'b0;
      end
      ct_d = ct_valid_d ? i_core_ct : ct_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         pt_blks_q   <= '0;
         first_q     <= 1'b0;
         to_q        <= '0;
         ct_sr_q     <= '0;
         key_q       <= '0;
         iv_q        <= '0;
         aad_q       <= '0;
         pt_q        <= '0;
         aad_size_q  <= '0;
         pt_size_q   <= '0;
         new_inst_q  <= 1'b0;
         pt_inst_q   <= 1'b0;
         ct_q        <= '0;
         ct_valid_q  <= 1'b0;
         tag_q       <= '0;
         tag_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pt_blks_q   <= pt_blks_d;
         first_q     <= first_d;
         to_q        <= to_d;
         ct_sr_q     <= ct_sr_d;
         key_q       <= key_d;
         iv_q        <= iv_d;
         aad_q       <= aad_d;
         pt_q        <= pt_d;
         aad_size_q  <= aad_size_d;
         pt_size_q   <= pt_size_d;
         new_inst_q  <= new_inst_d;
         pt_inst_q   <= pt_inst_d;
         ct_q        <= ct_d;
         ct_valid_q  <= ct_valid_d;
         tag_q       <= tag_d;
         tag_valid_q <= tag_valid_d;
         err_q       <= err_d;
      end
   end

`ifdef GCM_SEQ_PERF_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (state_q == StIdle) begin
         if (i_start) perf_d = '0;
      end else if (state_q != StErr && perf_q != '1) begin
         perf_d = perf_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) perf_q <= '0;
      else        perf_q <= perf_d;
   end

   assign o_perf_cycles = perf_q;
`endif

   assign o_blk_ready         = (state_q == StAad) || (state_q == StPt);
   assign o_busy              = (state_q != StIdle);
   assign o_ct                = ct_q;
   assign o_ct_valid          = ct_valid_q;
   assign o_tag               = tag_q;
   assign o_tag_valid         = tag_valid_q;
   assign o_err               = err_q;
   assign o_core_new_instance = new_inst_q;
   assign o_core_pt_instance  = pt_inst_q;
   assign o_core_key          = key_q;
   assign o_core_iv           = iv_q;
   assign o_core_aad          = aad_q;
   assign o_core_pt           = pt_q;
   assign o_core_aad_size     = aad_size_q;
   assign o_core_pt_size      = pt_size_q;

endmodule
